// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: scans captured operands MSB first, one bit per
// clock, and stops at the first differing bit. Supports unsigned and two's-complement modes.
module serial_comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_d, done_d, g_d, e_d, l_d;
    logic             bit_a, bit_b;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            idx_q   <= TOP_IDX;
            busy    <= 1'b0;
            done    <= 1'b0;
            g       <= 1'b0;
            e       <= 1'b0;
            l       <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            idx_q   <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            g       <= g_d;
            e       <= e_d;
            l       <= l_d;
        end
    end

    assign bit_a = a_q[idx_q];
    assign bit_b = b_q[idx_q];

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        idx_d   = idx_q;
        busy_d  = busy;
        done_d  = 1'b0;
        g_d     = g;
        e_d     = e;
        l_d     = l;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    idx_d   = TOP_IDX;
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    l_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bit_a != bit_b) begin
                    // In signed mode the sign bit has inverted weight
                    if (sm_q && (idx_q == TOP_IDX)) begin
                        g_d = ~bit_a;
                        l_d = bit_a;
                    end else begin
                        g_d = bit_a;
                        l_d = ~bit_a;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    e_d     = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
